// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response plus the decode-side
// instruction handshake and next-PC controls. master = fetch unit, slave = environment.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch;
    logic        zero;
    logic        jal;
    logic        jalr;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic [31:0] instret;
    logic        fetch_fault;

    modport master (
        output imem_req_valid, imem_addr, instr, pc, pc_plus4, instr_valid, instret, fetch_fault,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               branch, zero, jal, jalr, imm, alu_result
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr, pc, pc_plus4, instr_valid, instret, fetch_fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               branch, zero, jal, jalr, imm, alu_result
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: PC register, one outstanding imem fetch, one instruction held for decode.
// Optional misaligned-target trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, FAULT} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instret;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_rel;
    logic [31:0] w_pc_target;
    logic [31:0] w_pc_next;
    logic        w_misalign;
    logic        w_accept;
    logic        w_capture;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pc_rel   = r_pc + bus.imm;
    assign w_accept   = (r_state == HOLD) && bus.instr_ready;
    assign w_capture  = (r_state == WAIT) && bus.imem_rsp_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_misalign = (r_pc[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // jalr beats jal, which beats a taken branch
    always_comb begin
        w_pc_target = w_pc_plus4;
        if (bus.jalr) begin
            w_pc_target = bus.alu_result & ~32'h1;
        end else if (bus.jal || (bus.branch && bus.zero)) begin
            w_pc_target = w_pc_rel;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_pc_next = w_pc_target;
`else
    assign w_pc_next = w_pc_target & ~32'h3;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = FETCH;
            FETCH: begin
                if (w_misalign) begin
                    w_state_next = FAULT;
                end else if (bus.imem_req_ready) begin
                    w_state_next = WAIT;
                end
            end
            WAIT:    if (bus.imem_rsp_valid) w_state_next = HOLD;
            HOLD:    if (bus.instr_ready) w_state_next = FETCH;
            FAULT:   w_state_next = FAULT;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_instr   <= 32'h0000_0013;
            r_instret <= 32'd0;
        end else begin
            if (w_capture) begin
                r_instr <= bus.imem_rsp_data;
            end
            if (w_accept) begin
                r_pc      <= w_pc_next;
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    // every output is a register or a decode of state/pc; no input reaches an output combinationally
    assign bus.imem_req_valid = (r_state == FETCH) && !w_misalign;
    assign bus.imem_addr      = r_pc;
    assign bus.instr          = r_instr;
    assign bus.pc             = r_pc;
    assign bus.pc_plus4       = w_pc_plus4;
    assign bus.instr_valid    = (r_state == HOLD);
    assign bus.instret        = r_instret;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.fetch_fault    = (r_state == FAULT);
`else
    assign bus.fetch_fault    = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios, then a randomized run scored against a queue-based reference model.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic clk = 1'b0;
    logic reset = 1'b1;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] cnt;
    } hold_t;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] exp_addr_q[$];
    hold_t       exp_hold_q[$];
    bit          rand_en   = 1'b0;
    bit          mon_en    = 1'b0;
    bit          iv_m      = 1'b0;
    bit          waiting_m = 1'b0;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          pend = 1'b0;
    int          dly  = 0;
    logic [31:0] paddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_total++;
        n_bad++;
        $display("FAIL %s: got=event want=none", name);
    endtask

    // instruction memory contents: a fixed scramble of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // architectural next-PC rule
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic br, input logic z,
                                             input logic j, input logic jr,
                                             input logic [31:0] im, input logic [31:0] alu);
        logic [31:0] t;
        if (jr)                t = alu & ~32'h1;
        else if (j || (br && z)) t = pc + im;
        else                   t = pc + 32'd4;
`ifndef FETCH_MISALIGN_TRAP_EN
        t[1:0] = 2'b00;
`endif
        return t;
    endfunction

    task automatic zero_inputs();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;
        bus.instr_ready    = 1'b0;
        bus.branch         = 1'b0;
        bus.zero           = 1'b0;
        bus.jal            = 1'b0;
        bus.jalr           = 1'b0;
        bus.imm            = 32'd0;
        bus.alu_result     = 32'd0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"}, bus.pc, RST_PC);
        chk({tag, "_addr"}, bus.imem_addr, RST_PC);
        chk({tag, "_instr"}, bus.instr, 32'h0000_0013);
        chk({tag, "_instret"}, bus.instret, 32'd0);
        chk({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
        chk({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
        chk({tag, "_fault"}, 32'(bus.fetch_fault), 32'd0);
    endtask

    // One directed instruction: entered at posedge+1 with the unit in IDLE/FETCH, returns just after acceptance.
    // ctl = {jalr, jal, branch, zero}
    task automatic do_fetch(input logic [31:0] exp_pc, input int req_stall, input int rsp_dly,
                            input int hold_stall, input logic [3:0] ctl,
                            input logic [31:0] im, input logic [31:0] alu);
        logic [31:0] data;
        int          stalls;
        bit          accepted;
        data     = mem_word(exp_pc);
        stalls   = 0;
        accepted = 1'b0;
        for (int c = 0; c < 40 && !accepted; c++) begin
            bus.imem_req_ready = (stalls >= req_stall);
            @(negedge clk);
            if (bus.imem_req_valid) begin
                chk("d_imem_addr", bus.imem_addr, exp_pc);
                if (bus.imem_req_ready) accepted = 1'b1;
                else stalls++;
            end
            @(posedge clk); #1;
        end
        bus.imem_req_ready = 1'b0;
        if (!accepted) fail_now("d_req_timeout");
        for (int d = 0; d < rsp_dly; d++) begin
            @(negedge clk);
            chk("d_early_valid", 32'(bus.instr_valid), 32'd0);
            @(posedge clk); #1;
        end
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        @(negedge clk);
        chk("d_valid_before_capture", 32'(bus.instr_valid), 32'd0);
        @(posedge clk); #1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("d_instr_valid", 32'(bus.instr_valid), 32'd1);
        chk("d_instr", bus.instr, data);
        chk("d_pc", bus.pc, exp_pc);
        chk("d_pc_plus4", bus.pc_plus4, exp_pc + 32'd4);
        chk("d_instret", bus.instret, m_cnt);
        for (int h = 0; h < hold_stall; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("d_hold_valid", 32'(bus.instr_valid), 32'd1);
            chk("d_hold_instr", bus.instr, data);
            chk("d_hold_pc", bus.pc, exp_pc);
            chk("d_hold_instret", bus.instret, m_cnt);
        end
        {bus.jalr, bus.jal, bus.branch, bus.zero} = ctl;
        bus.imm         = im;
        bus.alu_result  = alu;
        bus.instr_ready = 1'b1;
        $display("fetch pc=%h instr=%h ctl=%b imm=%h alu=%h model_next=%h", exp_pc, data, ctl, im, alu,
                 ref_next(exp_pc, ctl[1], ctl[0], ctl[2], ctl[3], im, alu));
        @(posedge clk); #1;
        zero_inputs();
        m_cnt = m_cnt + 32'd1;
    endtask

    // random driver and reference model: memory with variable latency, random stalls and controls
    initial begin : driver
        logic [31:0] r;
        logic [31:0] nxt;
        forever begin
            @(negedge clk);
            if (rand_en) begin
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    pend  = 1'b1;
                    dly   = $urandom_range(0, 3);
                    paddr = bus.imem_addr;
                end
                if (bus.instr_valid && bus.instr_ready) begin
                    nxt   = ref_next(m_pc, bus.branch, bus.zero, bus.jal, bus.jalr, bus.imm, bus.alu_result);
                    m_pc  = nxt;
                    m_cnt = m_cnt + 32'd1;
                    exp_addr_q.push_back(nxt);
                    exp_hold_q.push_back('{instr: mem_word(nxt), pc: nxt, cnt: m_cnt});
                end
            end
            @(posedge clk); #1;
            if (rand_en) begin
                bus.imem_req_ready = ($urandom_range(0, 3) != 0);
                if (pend && dly == 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = mem_word(paddr);
                    pend = 1'b0;
                end else begin
                    if (pend) dly--;
                    // stray pulses outside WAIT must be ignored
                    bus.imem_rsp_valid = !pend && ($urandom_range(0, 4) == 0);
                    bus.imem_rsp_data  = $urandom;
                end
                r = $urandom;
                bus.instr_ready = r[8];
                bus.branch      = r[0];
                bus.zero        = r[1];
                bus.jal         = (r[4:2] == 3'd0);
                bus.jalr        = (r[7:5] == 3'd0);
                r = $urandom;
                bus.imm         = {{20{r[11]}}, r[11:0]};
                bus.alu_result  = {16'd0, r[31:16]};
`ifdef FETCH_MISALIGN_TRAP_EN
                bus.imm[1:0]      = 2'b00;
                bus.alu_result[1] = 1'b0;
`endif
            end
        end
    end

    // monitor: scores every presented request and instruction against the model queues
    initial begin : monitor
        hold_t e;
        bit    nxt_iv;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("r_instr_valid", 32'(bus.instr_valid), 32'(iv_m));
                chk("r_fault", 32'(bus.fetch_fault), 32'd0);
                if (bus.imem_req_valid) begin
                    if (exp_addr_q.size() == 0) fail_now("r_unexpected_req");
                    else begin
                        chk("r_imem_addr", bus.imem_addr, exp_addr_q[0]);
                        if (bus.imem_req_ready) void'(exp_addr_q.pop_front());
                    end
                end
                if (bus.instr_valid) begin
                    if (exp_hold_q.size() == 0) fail_now("r_unexpected_instr");
                    else begin
                        e = exp_hold_q[0];
                        chk("r_instr", bus.instr, e.instr);
                        chk("r_pc", bus.pc, e.pc);
                        chk("r_pc_plus4", bus.pc_plus4, e.pc + 32'd4);
                        chk("r_instret", bus.instret, e.cnt);
                        if (bus.instr_ready) void'(exp_hold_q.pop_front());
                    end
                end
                nxt_iv = iv_m;
                if (iv_m && bus.instr_ready) nxt_iv = 1'b0;
                if (waiting_m && bus.imem_rsp_valid) begin
                    nxt_iv    = 1'b1;
                    waiting_m = 1'b0;
                end
                if (bus.imem_req_valid && bus.imem_req_ready) waiting_m = 1'b1;
                iv_m = nxt_iv;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        zero_inputs();
        m_cnt = 32'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        do_fetch(32'h100, 0, 0, 0, 4'b0000, 32'd0, 32'd0);
        do_fetch(32'h104, 0, 0, 0, 4'b0000, 32'd0, 32'd0);
        do_fetch(32'h108, 0, 0, 0, 4'b0000, 32'd0, 32'd0);
        do_fetch(32'h10C, 0, 0, 0, 4'b0000, 32'd0, 32'd0);
        do_fetch(32'h110, 0, 0, 0, 4'b0011, 32'hFFFF_FFF8, 32'd0);
        do_fetch(32'h108, 0, 0, 0, 4'b0000, 32'd0, 32'd0);
        do_fetch(32'h10C, 0, 0, 0, 4'b0000, 32'd0, 32'd0);
        do_fetch(32'h110, 0, 0, 0, 4'b0010, 32'hFFFF_FFF8, 32'd0);
        do_fetch(32'h114, 0, 0, 0, 4'b0100, 32'h0000_00EC, 32'd0);
        do_fetch(32'h200, 0, 0, 0, 4'b1100, 32'h0000_0040, 32'h0000_0301);
        do_fetch(32'h300, 4, 3, 5, 4'b0000, 32'd0, 32'd0);
        do_fetch(32'h304, 0, 0, 0, 4'b1000, 32'd0, 32'h0000_0302);
`ifdef FETCH_MISALIGN_TRAP_EN
        bus.imem_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("trap_fault", 32'(bus.fetch_fault), (k > 0) ? 32'd1 : 32'd0);
            chk("trap_no_req", 32'(bus.imem_req_valid), 32'd0);
            chk("trap_no_valid", 32'(bus.instr_valid), 32'd0);
        end
        @(posedge clk); #1;
        bus.imem_req_ready = 1'b0;
`else
        do_fetch(32'h300, 0, 0, 0, 4'b0000, 32'd0, 32'd0);
`endif

        // randomized run
        reset = 1'b1;
        #1;
        chk_reset_vals("rst2");
        exp_addr_q.delete();
        exp_hold_q.delete();
        m_pc  = RST_PC;
        m_cnt = 32'd0;
        exp_addr_q.push_back(RST_PC);
        exp_hold_q.push_back('{instr: mem_word(RST_PC), pc: RST_PC, cnt: 32'd0});
        iv_m      = 1'b0;
        waiting_m = 1'b0;
        pend      = 1'b0;
        @(negedge clk);
        reset   = 1'b0;
        rand_en = 1'b1;
        mon_en  = 1'b1;
        repeat (3000) @(negedge clk);
        #2;
        rand_en = 1'b0;
        mon_en  = 1'b0;
        zero_inputs();
        $display("random run retired=%0d", m_cnt);
        chk("r_progress", 32'(m_cnt > 32'd100), 32'd1);

        // reset while waiting for a response, then a late response
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        bus.imem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.imem_req_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("wr_async_pc", bus.pc, RST_PC);
        chk("wr_async_valid", 32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.imem_rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("wr_valid", 32'(bus.instr_valid), 32'd0);
            chk("wr_pc", bus.pc, RST_PC);
            chk("wr_instret", bus.instret, 32'd0);
            chk("wr_instr", bus.instr, 32'h0000_0013);
            chk("wr_refetch", 32'(bus.imem_req_valid), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
